// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one byte-wide SPI master between NUM_REQ clients.
// Each grant runs one transaction: start pulse, wait for done or timeout, ack.
module spi_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [NUM_REQ-1:0]        grant_oh_o,
  output logic                      mst_start_o,
  output logic [DATA_W-1:0]         mst_wdata_o,
  input  logic [DATA_W-1:0]         mst_rdata_i,
  input  logic                      mst_done_i,
  output logic                      mst_abort_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               abort_q, abort_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  // First set request at or after the pointer, wrapping NUM_REQ-1 -> 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_valid && req_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    err_d   = err_q;
    start_d = 1'b0;
    wdata_d = wdata_q;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          idx_d   = pick_idx;
          wdata_d = wdata_i[pick_idx*DATA_W +: DATA_W];
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done is tested first so it wins over the final timeout cycle.
        if (mst_done_i) begin
          rdata_d = mst_rdata_i;
          err_d   = 1'b0;
          ack_d   = grant_q;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ack_d   = grant_q;
          abort_d = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        grant_d = '0;
        ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      wdata_q <= '0;
      abort_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      wdata_q <= wdata_d;
      abort_q <= abort_d;
    end
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign grant_oh_o  = grant_q;
  assign mst_start_o = start_q;
  assign mst_wdata_o = wdata_q;
  assign mst_abort_o = abort_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: the bench plays the SPI master and all
// requesters and compares outputs against hand-computed expectations.
module tb_spi_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] wdata = {8'h44, 8'h33, 8'h22, 8'hA5};
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        err;
  logic        busy;
  logic [3:0]  grant_oh;
  logic        mst_start;
  logic [7:0]  mst_wdata;
  logic [7:0]  mst_rdata = 8'hEE;
  logic        mst_done = 1'b0;
  logic        mst_abort;

  int n_cmp = 0;
  int n_err = 0;

  spi_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .wdata_i(wdata),
    .ack_o(ack), .rdata_o(rdata), .err_o(err), .busy_o(busy),
    .grant_oh_o(grant_oh),
    .mst_start_o(mst_start), .mst_wdata_o(mst_wdata),
    .mst_rdata_i(mst_rdata), .mst_done_i(mst_done),
    .mst_abort_o(mst_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(grant_oh), 32'h0);
    check({tag, "_ack"},   32'(ack),      32'h0);
    check({tag, "_rdata"}, 32'(rdata),    32'h0);
    check({tag, "_err"},   32'(err),      32'h0);
    check({tag, "_busy"},  32'(busy),     32'h0);
    check({tag, "_start"}, 32'(mst_start), 32'h0);
    check({tag, "_wdata"}, 32'(mst_wdata), 32'h0);
    check({tag, "_abort"}, 32'(mst_abort), 32'h0);
  endtask

  // One full transaction for requester idx. delay<0 means the master never
  // answers. hold_mask is raised (and kept) and pulse_mask raised for one
  // cycle, both at WAIT-relative cycle mid.
  task automatic serve(input int idx, input int delay, input logic [7:0] rd,
                       input logic [3:0] hold_mask, input logic [3:0] pulse_mask,
                       input int mid);
    int         cyc;
    int         starts;
    int         aborts;
    int         hold_bad;
    int         exp_lat;
    logic [3:0] exp_g;
    logic       exp_err;
    exp_g   = 4'b0001 << idx;
    exp_err = (delay < 0);
    exp_lat = (delay >= 0) ? delay + 1 : TIMEOUT + 1;

    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (mst_start !== 1'b1 && cyc < 20);
    check($sformatf("start_lat_r%0d", idx), 32'(cyc), 32'd1);
    check($sformatf("grant_r%0d", idx), 32'(grant_oh), 32'(exp_g));
    check($sformatf("mst_wdata_r%0d", idx), 32'(mst_wdata), 32'(wdata[idx*8 +: 8]));
    check($sformatf("busy_r%0d", idx), 32'(busy), 32'd1);

    cyc = 0; starts = 0; aborts = 0; hold_bad = 0;
    while (ack === 4'b0000 && cyc < 200) begin
      mst_done  = (cyc == delay);
      mst_rdata = (cyc == delay) ? rd : 8'hEE;
      if (cyc == mid)     req = req | hold_mask | pulse_mask;
      if (cyc == mid + 1) req = req & ~pulse_mask;
      if (cyc > 0 && mst_start === 1'b1) starts++;
      if (mst_abort === 1'b1) aborts++;
      if (grant_oh !== exp_g) hold_bad++;
      tick();
      cyc++;
    end
    mst_done  = 1'b0;
    mst_rdata = 8'hEE;

    check($sformatf("ack_lat_r%0d", idx), 32'(cyc), 32'(exp_lat));
    check($sformatf("ack_r%0d", idx), 32'(ack), 32'(exp_g));
    check($sformatf("rdata_r%0d", idx), 32'(rdata), exp_err ? 32'h0 : 32'(rd));
    check($sformatf("err_r%0d", idx), 32'(err), 32'(exp_err));
    check($sformatf("abort_r%0d", idx), 32'(mst_abort), 32'(exp_err));
    check($sformatf("extra_start_r%0d", idx), 32'(starts), 32'd0);
    check($sformatf("early_abort_r%0d", idx), 32'(aborts), 32'd0);
    check($sformatf("grant_hold_r%0d", idx), 32'(hold_bad), 32'd0);

    req[idx] = 1'b0;
    tick();
    check($sformatf("ack_clr_r%0d", idx), 32'(ack), 32'h0);
    check($sformatf("abort_clr_r%0d", idx), 32'(mst_abort), 32'h0);
    check($sformatf("grant_clr_r%0d", idx), 32'(grant_oh), 32'h0);
    check($sformatf("idle_r%0d", idx), 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    mst_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int busy_seen;
    int ack3_seen;

    // Reset values
    do_reset();
    check_all_zero("reset");

    // Single transfer: req0, byte A5, master answers 3C 20 cycles after start
    req = 4'b0001;
    serve(0, 20, 8'h3C, 4'b0000, 4'b0000, -10);

    // Round-robin from reset: 0,1,2,3 then 0,2
    do_reset();
    req = 4'b1111;
    serve(0, 3, 8'h10, 4'b0000, 4'b0000, -10);
    serve(1, 4, 8'h11, 4'b0000, 4'b0000, -10);
    serve(2, 5, 8'h12, 4'b0000, 4'b0000, -10);
    serve(3, 6, 8'h13, 4'b0000, 4'b0000, -10);
    req = 4'b0101;
    serve(0, 2, 8'h20, 4'b0000, 4'b0000, -10);
    serve(2, 2, 8'h22, 4'b0000, 4'b0000, -10);

    // Timeout: master never answers
    req = 4'b0010;
    serve(1, -1, 8'h00, 4'b0000, 4'b0000, -10);

    // Done on the last WAIT cycle wins; req1 raised mid-transfer waits its turn
    req = 4'b0001;
    serve(0, TIMEOUT, 8'h5A, 4'b0010, 4'b0000, 10);

    // req3 pulsed for one cycle while busy is never granted
    serve(1, 8, 8'h77, 4'b0000, 4'b1000, 3);
    busy_seen = 0;
    ack3_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy === 1'b1) busy_seen++;
      if (ack[3] === 1'b1) ack3_seen++;
      tick();
    end
    check("pulse_no_grant", 32'(busy_seen), 32'd0);
    check("pulse_no_ack3", 32'(ack3_seen), 32'd0);

    // Reset in WAIT drops the transfer, pointer returns to 0
    req = 4'b0100;
    tick();
    check("r6_start", 32'(mst_start), 32'd1);
    check("r6_grant", 32'(grant_oh), 32'h4);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    req = 4'b0110;
    tick();
    check("midrst_ack", 32'(ack), 32'h0);
    tick();
    rst = 1'b0;
    serve(1, 4, 8'h61, 4'b0000, 4'b0000, -10);
    serve(2, 4, 8'h62, 4'b0000, 4'b0000, -10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
